arm7tdmi_lsu: RTL

- Load/store unit between decode/register-read and the data memory bus.
- Accepts one decoded single-data-transfer op (LDR/STR/LDRB/STRB, pre/post-indexed, up/down, writeback).
- Computes the effective address, drives the bus with byte enables and lane-replicated store data, and waits on mem_ready.
- Returns the aligned/rotated load data and the updated base value to the register-file write port.

---
 rtl/arm7tdmi_pkg.sv | 42 ++++
 rtl/arm7tdmi_lsu_align.sv | 40 ++++
 rtl/arm7tdmi_lsu.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm7tdmi_pkg.sv
// Shared types and helpers for the ARM7TDMI load/store unit.
package arm7tdmi_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 12;
    localparam int unsigned REG_W = 4;
    localparam int unsigned BE_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic             load;
        logic             is_byte;
        logic             pre;
        logic             up;
        logic             wb;
        logic             imm_en;
        logic [IMM_W-1:0] imm;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rn;
    } lsu_req_t;

    localparam logic [BE_W-1:0] LSU_WORD_BE = 4'b1111;

    // Base +/- offset, wrapping modulo 2^32.
    function automatic logic [XLEN-1:0] lsu_sum(
        input logic             up,
        input logic             imm_en,
        input logic [IMM_W-1:0] imm,
        input logic [XLEN-1:0]  rn_val,
        input logic [XLEN-1:0]  rm_val
    );
        logic [XLEN-1:0] off;
        off = imm_en ? XLEN'(imm) : rm_val;
        return up ? (rn_val + off) : (rn_val - off);
    endfunction

endpackage

// File: rtl/arm7tdmi_lsu_align.sv
// Byte-lane steering: store replication/byte enables and load extraction/rotation.
module arm7tdmi_lsu_align
    import arm7tdmi_pkg::*;
#(
    parameter bit ROTATE_UNALIGNED = 1'b1
) (
    input  logic            st_byte_i,
    input  logic [1:0]      st_lane_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [BE_W-1:0] st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic            ld_byte_i,
    input  logic [1:0]      ld_lane_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] rot_c;

    always_comb begin
        st_be_o    = st_byte_i ? (BE_W'(1) << st_lane_i) : LSU_WORD_BE;
        st_wdata_o = st_byte_i ? {4{st_data_i[7:0]}} : st_data_i;
    end

    // Rotating right by 8*lane also brings the addressed byte into bits [7:0].
    always_comb begin
        case (ld_lane_i)
            2'd1:    rot_c = {rdata_i[7:0],  rdata_i[31:8]};
            2'd2:    rot_c = {rdata_i[15:0], rdata_i[31:16]};
            2'd3:    rot_c = {rdata_i[23:0], rdata_i[31:24]};
            default: rot_c = rdata_i;
        endcase
        if (ld_byte_i) begin
            ld_data_o = XLEN'(rot_c[7:0]);
        end else begin
            ld_data_o = ROTATE_UNALIGNED ? rot_c : rdata_i;
        end
    end

endmodule

// File: rtl/arm7tdmi_lsu.sv
// ARM7TDMI single-data-transfer load/store unit (IDLE -> ACCESS -> DONE).
// Optional data-abort support is enabled with `define ARM7TDMI_LSU_ABORT_EN.
module arm7tdmi_lsu
    import arm7tdmi_pkg::*;
#(
    parameter int MAX_WAIT         = 16,
    parameter bit ROTATE_UNALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             flush,
    input  logic             op_load,
    input  logic             op_byte,
    input  logic             op_pre,
    input  logic             op_up,
    input  logic             op_wb,
    input  logic             op_imm_en,
    input  logic [IMM_W-1:0] op_imm,
    input  logic [REG_W-1:0] op_rd,
    input  logic [REG_W-1:0] op_rn,
    input  logic [XLEN-1:0]  rn_data,
    input  logic [XLEN-1:0]  rm_data,
    input  logic [XLEN-1:0]  rd_data,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    output logic [BE_W-1:0]  mem_be,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
`ifdef ARM7TDMI_LSU_ABORT_EN
    input  logic             mem_abort,
    output logic             data_abort,
`endif
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_rd_en,
    output logic [XLEN-1:0]  wb_data,
    output logic             base_wb_en,
    output logic [REG_W-1:0] base_wb_rn,
    output logic [XLEN-1:0]  base_wb_data,
    output logic             bus_timeout
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    lsu_state_t        state_q, state_d;
    logic              rdy_q, rdy_d;
    lsu_req_t          req_q, req_d, req_c;
    logic [XLEN-1:0]   rn_q, rn_d, rm_q, rm_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              wbv_q, wbv_d, rd_en_q, rd_en_d, bwe_q, bwe_d, tmo_q, tmo_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d, bwrn_q, bwrn_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d, bwdata_q, bwdata_d;
    logic              abort_q, abort_d;

    logic              req_ready_c, accept_c, timeout_c, abort_c, ok_c;
    logic [XLEN-1:0]   sum_c, ea_c, sum_l_c, ld_data_c, st_wdata_c;
    logic [1:0]        lane_l_c;
    logic [BE_W-1:0]   st_be_c;

`ifdef ARM7TDMI_LSU_ABORT_EN
    assign abort_c    = mem_abort;
    assign data_abort = abort_q;
`else
    assign abort_c    = 1'b0;
`endif

    assign req_c = '{load: op_load, is_byte: op_byte, pre: op_pre, up: op_up, wb: op_wb,
                     imm_en: op_imm_en, imm: op_imm, rd: op_rd, rn: op_rn};

    // rdy_q keeps req_ready low during reset and through ACCESS/DONE.
    assign req_ready_c = rdy_q && !flush;
    assign accept_c    = (state_q == IDLE) && req_ready_c && req_valid;
    assign timeout_c   = (MAX_WAIT > 0) && !mem_ready && (wait_q == WAIT_W'(MAX_WAIT - 1));
    assign ok_c        = mem_ready && !abort_c;

    assign sum_c    = lsu_sum(op_up, op_imm_en, op_imm, rn_data, rm_data);
    assign ea_c     = op_pre ? sum_c : rn_data;
    assign sum_l_c  = lsu_sum(req_q.up, req_q.imm_en, req_q.imm, rn_q, rm_q);
    assign lane_l_c = req_q.pre ? sum_l_c[1:0] : rn_q[1:0];

    arm7tdmi_lsu_align #(.ROTATE_UNALIGNED(ROTATE_UNALIGNED)) u_align (
        .st_byte_i  (op_byte),
        .st_lane_i  (ea_c[1:0]),
        .st_data_i  (rd_data),
        .st_be_o    (st_be_c),
        .st_wdata_o (st_wdata_c),
        .ld_byte_i  (req_q.is_byte),
        .ld_lane_i  (lane_l_c),
        .rdata_i    (mem_rdata),
        .ld_data_o  (ld_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = ACCESS;
            ACCESS:  if (mem_ready || timeout_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy_d     = (state_d == IDLE);
        req_d     = req_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        re_d      = re_q;
        be_d      = be_q;
        tmo_d     = tmo_q;
        wbv_d     = 1'b0;
        rd_en_d   = 1'b0;
        wb_rd_d   = '0;
        wb_data_d = '0;
        bwe_d     = 1'b0;
        bwrn_d    = '0;
        bwdata_d  = '0;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: if (accept_c) begin
                req_d   = req_c;
                rn_d    = rn_data;
                rm_d    = rm_data;
                wait_d  = '0;
                tmo_d   = 1'b0;
                addr_d  = op_byte ? ea_c : {ea_c[XLEN-1:2], 2'b00};
                wdata_d = op_load ? '0 : st_wdata_c;
                be_d    = st_be_c;
                we_d    = !op_load;
                re_d    = op_load;
            end
            ACCESS: if (mem_ready || timeout_c) begin
                addr_d    = '0;
                wdata_d   = '0;
                we_d      = 1'b0;
                re_d      = 1'b0;
                be_d      = '0;
                tmo_d     = timeout_c;
                abort_d   = mem_ready && abort_c;
                wbv_d     = 1'b1;
                rd_en_d   = ok_c && req_q.load;
                wb_rd_d   = req_q.load ? req_q.rd : '0;
                wb_data_d = (ok_c && req_q.load) ? ld_data_c : '0;
                // A load into its own base register keeps the loaded value.
                bwe_d     = ok_c && (!req_q.pre || req_q.wb)
                            && !(req_q.load && (req_q.rd == req_q.rn));
                bwrn_d    = req_q.rn;
                bwdata_d  = sum_l_c;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            req_q     <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            be_q      <= '0;
            tmo_q     <= 1'b0;
            wbv_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            bwe_q     <= 1'b0;
            bwrn_q    <= '0;
            bwdata_q  <= '0;
            abort_q   <= 1'b0;
        end else begin
            rdy_q     <= rdy_d;
            req_q     <= req_d;
            rn_q      <= rn_d;
            rm_q      <= rm_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            be_q      <= be_d;
            tmo_q     <= tmo_d;
            wbv_q     <= wbv_d;
            rd_en_q   <= rd_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            bwe_q     <= bwe_d;
            bwrn_q    <= bwrn_d;
            bwdata_q  <= bwdata_d;
            abort_q   <= abort_d;
        end
    end

    assign req_ready    = req_ready_c;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_we       = we_q;
    assign mem_re       = re_q;
    assign mem_be       = be_q;
    assign wb_valid     = wbv_q;
    assign wb_rd        = wb_rd_q;
    assign wb_rd_en     = rd_en_q;
    assign wb_data      = wb_data_q;
    assign base_wb_en   = bwe_q;
    assign base_wb_rn   = bwrn_q;
    assign base_wb_data = bwdata_q;
    assign bus_timeout  = tmo_q;

endmodule
